// File: rtl/regfile_fwd_n_pkg.sv
// Shared definitions for the forwarding register file.
//   - Default widths and stage count used as parameter defaults.
//   - fld_lo(): bit offset of field idx in a flattened bus of w-bit fields,
//     used to slice raddr, rdata and the per-stage forwarding buses.
package regfile_fwd_n_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_AW       = 5;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_NUM_FWD  = 3;

    localparam int CNT_W = 32;

    function automatic int fld_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_fwd_n_fwd_sel.sv
// Forwarding selector for one read operand.
// Picks the youngest in-flight stage writing the operand, else the write-port
// bypass, else the stored value, and reports whether the chosen stage is
// still waiting for its data.
// Ports:
//   addr_mode   1 = compare addresses (GPR), 0 = any enabled writer matches (HI/LO)
//   force_zero  operand is r0 or out of range: data 0, never not-ready
//   addr        operand address
//   fwd_we/fwd_rdy/fwd_waddr/fwd_wdata  per-stage write enable, ready, dest, data
//   wb_we/wb_addr/wb_data                write-port bypass
//   arr_data    stored value
//   data        selected operand value
//   not_ready   selected stage has no data yet
module regfile_fwd_n_fwd_sel
    import regfile_fwd_n_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int AW      = DEF_AW,
    parameter int NUM_FWD = DEF_NUM_FWD
) (
    input  logic                      addr_mode,
    input  logic                      force_zero,
    input  logic [AW-1:0]             addr,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD-1:0]        fwd_rdy,
    input  logic [NUM_FWD*AW-1:0]     fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic                      wb_we,
    input  logic [AW-1:0]             wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    input  logic [DATA_W-1:0]         arr_data,
    output logic [DATA_W-1:0]         data,
    output logic                      not_ready
);

    always_comb begin
        data      = arr_data;
        not_ready = 1'b0;
        if (wb_we && (!addr_mode || (wb_addr == addr))) begin
            data = wb_data;
        end
        // Walk oldest to youngest so the youngest match overrides; its ready
        // bit replaces any older one, so a ready older stage cannot hide a
        // younger one that is still pending.
        for (int s = NUM_FWD - 1; s >= 0; s--) begin
            if (fwd_we[s] && (!addr_mode || (fwd_waddr[fld_lo(s, AW) +: AW] == addr))) begin
                data      = fwd_wdata[fld_lo(s, DATA_W) +: DATA_W];
                not_ready = !fwd_rdy[s];
            end
        end
        if (force_zero) begin
            data      = '0;
            not_ready = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_fwd_n.sv
// Register file with HI/LO, multi-stage forwarding and load-use stall detection.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd_en, raddr, rdata      NUM_RD GPR read ports (flattened, port i at i*W)
//   we, waddr, wdata         GPR write port (WB commit)
//   hi_we/lo_we, hi_wdata/lo_wdata   HI/LO write port
//   fwd_*                    per-stage forwarding info, stage 0 youngest
//   hi_rd, lo_rd             HI/LO being read (stall qualification)
//   hi_out, lo_out           forwarded HI/LO
//   stall                    combinational hazard stall request
//   stall_cnt                saturating count of stalled cycles
module regfile_fwd_n
    import regfile_fwd_n_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int AW       = DEF_AW,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_FWD  = DEF_NUM_FWD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RD-1:0]         rd_en,
    input  logic [NUM_RD*AW-1:0]      raddr,
    output logic [NUM_RD*DATA_W-1:0]  rdata,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      hi_we,
    input  logic                      lo_we,
    input  logic [DATA_W-1:0]         hi_wdata,
    input  logic [DATA_W-1:0]         lo_wdata,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD-1:0]        fwd_rdy,
    input  logic [NUM_FWD*AW-1:0]     fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_hi_we,
    input  logic [NUM_FWD-1:0]        fwd_lo_we,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_hi,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_lo,
    input  logic                      hi_rd,
    input  logic                      lo_rd,
    output logic [DATA_W-1:0]         hi_out,
    output logic [DATA_W-1:0]         lo_out,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam logic [AW:0] NUM_REGS_W = (AW + 1)'(NUM_REGS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0]     gpr [NUM_REGS];
    logic [DATA_W-1:0]     hi_q;
    logic [DATA_W-1:0]     lo_q;
    logic [CNT_W-1:0]      stall_cnt_p0;
    logic [NUM_RD-1:0]     port_nr;
    logic                  hi_nr;
    logic                  lo_nr;
    logic                  waddr_ok;

    logic [NUM_FWD*AW-1:0] no_addr;
    assign no_addr = '0;

    assign waddr_ok = (waddr != '0) && ({1'b0, waddr} < NUM_REGS_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                gpr[r] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (we && waddr_ok) begin
                gpr[waddr] <= wdata;
            end
            if (hi_we) begin
                hi_q <= hi_wdata;
            end
            if (lo_we) begin
                lo_q <= lo_wdata;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ra_zero;
        assign ra      = raddr[fld_lo(i, AW) +: AW];
        assign ra_zero = (ra == '0) || ({1'b0, ra} >= NUM_REGS_W);

        regfile_fwd_n_fwd_sel #(.DATA_W(DATA_W), .AW(AW), .NUM_FWD(NUM_FWD)) u_sel (
            .addr_mode (1'b1),
            .force_zero(ra_zero),
            .addr      (ra),
            .fwd_we    (fwd_we),
            .fwd_rdy   (fwd_rdy),
            .fwd_waddr (fwd_waddr),
            .fwd_wdata (fwd_wdata),
            .wb_we     (we),
            .wb_addr   (waddr),
            .wb_data   (wdata),
            .arr_data  (gpr[ra]),
            .data      (rdata[fld_lo(i, DATA_W) +: DATA_W]),
            .not_ready (port_nr[i])
        );
    end

    regfile_fwd_n_fwd_sel #(.DATA_W(DATA_W), .AW(AW), .NUM_FWD(NUM_FWD)) u_sel_hi (
        .addr_mode (1'b0),
        .force_zero(1'b0),
        .addr      ('0),
        .fwd_we    (fwd_hi_we),
        .fwd_rdy   (fwd_rdy),
        .fwd_waddr (no_addr),
        .fwd_wdata (fwd_hi),
        .wb_we     (hi_we),
        .wb_addr   ('0),
        .wb_data   (hi_wdata),
        .arr_data  (hi_q),
        .data      (hi_out),
        .not_ready (hi_nr)
    );

    regfile_fwd_n_fwd_sel #(.DATA_W(DATA_W), .AW(AW), .NUM_FWD(NUM_FWD)) u_sel_lo (
        .addr_mode (1'b0),
        .force_zero(1'b0),
        .addr      ('0),
        .fwd_we    (fwd_lo_we),
        .fwd_rdy   (fwd_rdy),
        .fwd_waddr (no_addr),
        .fwd_wdata (fwd_lo),
        .wb_we     (lo_we),
        .wb_addr   ('0),
        .wb_data   (lo_wdata),
        .arr_data  (lo_q),
        .data      (lo_out),
        .not_ready (lo_nr)
    );

    // Port not-ready is already forced low for r0, so only rd_en qualifies it.
    assign stall = (|(rd_en & port_nr)) || (hi_rd && hi_nr) || (lo_rd && lo_nr);

    // Stall-cycle counter stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_p0 <= '0;
        end else if (stall) begin
            stall_cnt_p0 <= sat_inc(stall_cnt_p0);
        end
    end

    assign stall_cnt = stall_cnt_p0;

endmodule

// File: doc/regfile_fwd_n.md
Name: regfile_fwd_n

Overview:
Parametrised successor to the core's register file, instantiated in ID.
- Holds NUM_REGS general registers plus HI/LO, with asynchronous reset.
- Resolves read-after-write hazards by forwarding from NUM_FWD in-flight pipeline stages (EX, MEM, WB, …) and from the write port itself.
- Raises a load-use stall when the youngest matching producer has no data yet.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
DATA_W, 32, register data width
AW, 5, register address width
NUM_REGS, 32, number of GPRs; must be ≤ 2**AW; register 0 is hardwired to zero
NUM_RD, 2, number of GPR read ports
NUM_FWD, 3, number of forwarding stages; index 0 is the youngest (EX)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rd_en  in  NUM_RD  per-port read valid; only enabled ports can stall
raddr  in  NUM_RD*AW  read addresses, port i at bits [i*AW +: AW]
rdata  out  NUM_RD*DATA_W  read data
we  in  1  GPR write enable (WB commit)
waddr  in  AW  write address
wdata  in  DATA_W  write data
hi_we  in  1  HI write enable
lo_we  in  1  LO write enable
hi_wdata  in  DATA_W  HI write data
lo_wdata  in  DATA_W  LO write data
fwd_we  in  NUM_FWD  stage s writes a GPR
fwd_rdy  in  NUM_FWD  stage s data is valid (0 = load or multicycle result still pending)
fwd_waddr  in  NUM_FWD*AW  stage destination addresses
fwd_wdata  in  NUM_FWD*DATA_W  stage result data
fwd_hi_we  in  NUM_FWD  stage s writes HI
fwd_lo_we  in  NUM_FWD  stage s writes LO
fwd_hi  in  NUM_FWD*DATA_W  stage HI value
fwd_lo  in  NUM_FWD*DATA_W  stage LO value
hi_rd  in  1  HI is being read (for stall purposes)
lo_rd  in  1  LO is being read
hi_out  out  DATA_W  forwarded HI
lo_out  out  DATA_W  forwarded LO
stall  out  1  hazard stall request to the pipeline controller
stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
- Reset: asynchronous. All GPRs, HI, LO and stall_cnt go to 0. The combinational outputs then reflect zeroed state plus any forwarding inputs.
- GPR write: on posedge clk when we=1 and waddr≠0 and waddr<NUM_REGS. Writes to addresses ≥NUM_REGS are ignored.
- HI/LO write: on posedge clk, independently gated by hi_we and lo_we.
- GPR read, per port i, combinational, first match wins:
  - raddr=0 or raddr≥NUM_REGS → 0.
  - Otherwise the youngest stage s with fwd_we[s]=1 and fwd_waddr[s]=raddr supplies fwd_wdata[s].
  - Otherwise, if we=1 and waddr=raddr, the data is wdata (same-cycle write-through).
  - Otherwise the array value.
- Port stall: port i stalls when rd_en[i]=1, raddr≠0, and the selected stage has fwd_rdy[s]=0. Older stages with valid data must never mask a younger not-ready stage.
- HI/LO read: the same priority scheme using fwd_hi_we/fwd_lo_we, then hi_we/lo_we, then the stored value.
- HI/LO stall: hi_rd=1 and the selected HI stage is not ready (likewise for LO).
- stall is the OR of all port stalls, the HI stall and the LO stall. It is combinational, with zero latency.
- stall_cnt:
  - Increments on each posedge where stall=1.
  - Saturates at 32'hFFFF_FFFF; no wrap.
  - Only rst clears it.
- Simultaneous events:
  - The write port and a stage targeting the same register: the stage wins for reads; the write port still commits.
  - Reading and writing the same register in one cycle returns the new data.
- rst asserted mid-stall: stall_cnt clears immediately. stall itself still tracks its inputs.

Decomposition:
- Shared package/include (defines.vh): DATA_W, AW, NUM_FWD defaults, plus field offsets for the flattened forwarding bus.
- Sub-module fwd_sel: given an address (or HI/LO mode), the stage vectors and the write-port bypass, it returns {data, not_ready}.
  - Instantiated NUM_RD times for the GPR ports, plus once each for HI and LO.

Test Plan:
- Reset then read: assert rst, write r5=0x1234, read r5 → 0. After reset release, write r5=0x1234; next cycle read r5 → 0x1234 and stall=0.
- Register zero: write r0=0xFFFF_FFFF; read r0 → 0. A stage with waddr=0 and fwd_rdy=0 plus a read of r0 → stall=0.
- Forward priority: EX r3=0xA, MEM r3=0xB, WB r3=0xC → rdata=0xA. Drop EX → 0xB. Drop MEM → 0xC. Drop WB with we r3=0xD → 0xD.
- Load-use stall: EX fwd_we=1, fwd_rdy=0, r7; rd_en=1, raddr=r7 for 3 cycles → stall=1 and stall_cnt=3. With rd_en=0 → stall=0.
- Young-not-ready masking: EX r7 not ready and MEM r7=0x55 ready → stall=1, not forward 0x55.
- HI/LO: hi_we=1 with 0x11, lo_we=1 with 0x22, then read → 0x11/0x22. MEM fwd_hi=0x99 (ready) → hi_out=0x99 while lo_out stays 0x22.
